// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: per-source gateways, enable mask, fixed-priority
// claim/complete handshake, registered external_interrupt and WFI wake.
module ext_irq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic grant,
  input  logic done,
  output logic pending,
  output logic in_service
);
  typedef enum logic [1:0] {IDLE, PEND, INSV} gw_state_e;
  gw_state_e state;

  // Source level only matters in IDLE; a held line re-pends the cycle after completion.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (src)   state <= PEND;
        PEND:    if (grant) state <= INSV;
        INSV:    if (done)  state <= IDLE;
        default:            state <= IDLE;
      endcase
    end
  end

  assign pending    = (state == PEND);
  assign in_service = (state == INSV);
endmodule

module ext_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int IDW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_enable,
  input  logic               claim_req,
  output logic               claim_valid,
  output logic [IDW-1:0]     claim_id,
  input  logic               complete_req,
  input  logic [IDW-1:0]     complete_id,
  output logic               external_interrupt,
  input  logic               core_wfi,
  output logic               wfi_wake
);
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] done;
  logic [IDW-1:0]     win_id;

  assign cand = pending & enable;

  // Lowest-numbered candidate wins; scan from the top so the last hit is the lowest.
  always_comb begin
    win_id = '0;
    grant  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id   = IDW'(i + 1);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gen_gw
      // ID 0 and out-of-range IDs never match any source, so they fall out naturally.
      assign done[g] = complete_req && (complete_id == IDW'(g + 1));
      ext_irq_gateway u_gw (
        .clk       (clk),
        .rst       (rst),
        .src       (irq_src[g]),
        .grant     (claim_req & grant[g]),
        .done      (done[g]),
        .pending   (pending[g]),
        .in_service(in_service[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      enable             <= '0;
      claim_valid        <= 1'b0;
      claim_id           <= '0;
      external_interrupt <= 1'b0;
      wfi_wake           <= 1'b0;
    end else begin
      if (cfg_we) enable <= cfg_enable;
      claim_valid        <= claim_req;
      if (claim_req) claim_id <= win_id;
      external_interrupt <= |cand;
      wfi_wake           <= core_wfi & external_interrupt;
    end
  end

  logic unused_ok;
  assign unused_ok = ^in_service;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios plus randomized run
// against a cycle-level reference model of the gateway/claim rules.
module tb_ext_irq_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src;
  logic         cfg_we;
  logic [N-1:0] cfg_enable;
  logic         claim_req;
  logic         claim_valid;
  logic [3:0]   claim_id;
  logic         complete_req;
  logic [3:0]   complete_id;
  logic         external_interrupt;
  logic         core_wfi;
  logic         wfi_wake;

  int checks = 0;
  int failures = 0;

  // Reference model state: per-source pending / in-service flags.
  bit [N-1:0] m_pend, m_insv, m_en;
  bit         m_valid, m_ext, m_wake;
  bit [3:0]   m_id;

  always #5 clk = ~clk;

  ext_irq_ctrl #(.NUM_SRC(N), .IDW(4)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_enable(cfg_enable),
    .claim_req(claim_req), .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_req(complete_req), .complete_id(complete_id),
    .external_interrupt(external_interrupt), .core_wfi(core_wfi), .wfi_wake(wfi_wake)
  );

  task automatic tick();
    bit [N-1:0] p0, s0;
    int w;
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_insv = '0; m_en = '0;
      m_valid = 0; m_id = '0; m_ext = 0; m_wake = 0;
    end else begin
      p0 = m_pend; s0 = m_insv;
      m_wake = core_wfi && m_ext;
      m_ext = |(p0 & m_en);
      w = 0;
      for (int i = 0; i < N; i++) if (w == 0 && p0[i] && m_en[i]) w = i + 1;
      m_valid = claim_req;
      if (claim_req) begin
        m_id = 4'(w);
        if (w != 0) begin m_pend[w-1] = 0; m_insv[w-1] = 1; end
      end
      if (complete_req && complete_id >= 1 && complete_id <= N && s0[complete_id-1])
        m_insv[complete_id-1] = 0;
      for (int i = 0; i < N; i++) if (!p0[i] && !s0[i] && irq_src[i]) m_pend[i] = 1;
      if (cfg_we) m_en = cfg_enable;
    end
    #1;
  endtask

  task automatic quiet();
    rst = 0; cfg_we = 0; claim_req = 0; complete_req = 0; complete_id = '0;
  endtask

  task automatic test_reset();
    irq_src = '0; cfg_enable = '0; core_wfi = 0; quiet();
    rst = 1; claim_req = 1; tick(); tick();
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", claim_valid); end
    checks++; if (claim_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", claim_id); end
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL reset_ext got=%0b exp=0", external_interrupt); end
    checks++; if (wfi_wake !== 1'b0) begin failures++; $display("FAIL reset_wake got=%0b exp=0", wfi_wake); end
    quiet();
  endtask

  task automatic test_basic();
    cfg_we = 1; cfg_enable = 8'hFF; tick(); quiet();
    irq_src = 8'h04; tick();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL basic_ext_early got=%0b exp=0", external_interrupt); end
    irq_src = '0; tick();
    checks++; if (external_interrupt !== 1'b1) begin failures++; $display("FAIL basic_ext got=%0b exp=1", external_interrupt); end
    claim_req = 1; tick(); claim_req = 0;
    checks++; if (claim_valid !== 1'b1 || claim_id !== 4'd3) begin failures++; $display("FAIL basic_claim got=%0b/%0d exp=1/3", claim_valid, claim_id); end
    tick();
    checks++; if (claim_valid !== 1'b0 || claim_id !== 4'd3 || external_interrupt !== 1'b0) begin
      failures++; $display("FAIL basic_after got=%0b/%0d/%0b exp=0/3/0", claim_valid, claim_id, external_interrupt); end
    complete_req = 1; complete_id = 4'd3; tick(); quiet();
  endtask

  task automatic test_priority();
    irq_src = 8'hA0; tick(); irq_src = '0; tick();
    claim_req = 1; tick();
    checks++; if (claim_id !== 4'd6) begin failures++; $display("FAIL prio_first got=%0d exp=6", claim_id); end
    tick();
    checks++; if (claim_id !== 4'd8) begin failures++; $display("FAIL prio_second got=%0d exp=8", claim_id); end
    tick(); claim_req = 0;
    checks++; if (claim_valid !== 1'b1 || claim_id !== 4'd0) begin failures++; $display("FAIL prio_none got=%0b/%0d exp=1/0", claim_valid, claim_id); end
    complete_req = 1; complete_id = 4'd6; tick(); complete_id = 4'd8; tick(); quiet(); tick();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL prio_drain got=%0b exp=0", external_interrupt); end
  endtask

  task automatic test_complete();
    irq_src = 8'h01; tick(); tick();
    claim_req = 1; tick(); quiet();
    checks++; if (claim_id !== 4'd1) begin failures++; $display("FAIL cmp_claim got=%0d exp=1", claim_id); end
    complete_req = 1; complete_id = 4'd1; tick(); quiet();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL cmp_ext0 got=%0b exp=0", external_interrupt); end
    tick();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL cmp_ext1 got=%0b exp=0", external_interrupt); end
    tick();
    checks++; if (external_interrupt !== 1'b1) begin failures++; $display("FAIL cmp_repend got=%0b exp=1", external_interrupt); end
    claim_req = 1; tick(); quiet();
    complete_req = 1; complete_id = 4'd5; tick(); quiet();
    claim_req = 1; tick(); quiet();
    checks++; if (claim_valid !== 1'b1 || claim_id !== 4'd0) begin failures++; $display("FAIL cmp_badid got=%0b/%0d exp=1/0", claim_valid, claim_id); end
    irq_src = '0; complete_req = 1; complete_id = 4'd1; tick(); quiet(); tick();
  endtask

  task automatic test_mask();
    cfg_we = 1; cfg_enable = 8'h00; tick(); quiet();
    irq_src = 8'h01; tick(); irq_src = '0; tick(); tick();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL mask_off got=%0b exp=0", external_interrupt); end
    cfg_we = 1; cfg_enable = 8'h01; tick(); quiet();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL mask_lag got=%0b exp=0", external_interrupt); end
    tick();
    checks++; if (external_interrupt !== 1'b1) begin failures++; $display("FAIL mask_on got=%0b exp=1", external_interrupt); end
    cfg_we = 1; cfg_enable = 8'h00; tick(); quiet(); tick();
    checks++; if (external_interrupt !== 1'b0) begin failures++; $display("FAIL mask_disable got=%0b exp=0", external_interrupt); end
    cfg_we = 1; cfg_enable = 8'hFF; tick(); quiet();
    claim_req = 1; tick(); quiet();
    checks++; if (claim_id !== 4'd1) begin failures++; $display("FAIL mask_kept got=%0d exp=1", claim_id); end
    complete_req = 1; complete_id = 4'd1; tick(); quiet();
  endtask

  task automatic test_simul();
    irq_src = 8'h02; tick();
    claim_req = 1; tick(); quiet();
    checks++; if (claim_id !== 4'd2) begin failures++; $display("FAIL sim_claim got=%0d exp=2", claim_id); end
    claim_req = 1; complete_req = 1; complete_id = 4'd2; tick(); quiet();
    checks++; if (claim_valid !== 1'b1 || claim_id !== 4'd0) begin failures++; $display("FAIL sim_both got=%0b/%0d exp=1/0", claim_valid, claim_id); end
    tick();
    claim_req = 1; tick(); quiet();
    checks++; if (claim_id !== 4'd2) begin failures++; $display("FAIL sim_next got=%0d exp=2", claim_id); end
    irq_src = '0; complete_req = 1; complete_id = 4'd2; tick(); quiet();
  endtask

  task automatic test_wfi();
    core_wfi = 1; irq_src = 8'h10; tick(); irq_src = '0; tick();
    checks++; if (external_interrupt !== 1'b1 || wfi_wake !== 1'b0) begin
      failures++; $display("FAIL wfi_lag got=%0b/%0b exp=1/0", external_interrupt, wfi_wake); end
    tick();
    checks++; if (wfi_wake !== 1'b1) begin failures++; $display("FAIL wfi_wake got=%0b exp=1", wfi_wake); end
    rst = 1; claim_req = 1; tick(); quiet(); core_wfi = 0;
    checks++; if (claim_valid !== 1'b0 || claim_id !== 4'd0 || external_interrupt !== 1'b0 || wfi_wake !== 1'b0) begin
      failures++; $display("FAIL wfi_rst got=%0b/%0d/%0b/%0b exp=0/0/0/0", claim_valid, claim_id, external_interrupt, wfi_wake); end
  endtask

  task automatic test_random();
    rst = 1; tick(); quiet();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      irq_src      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_enable   = 8'($urandom);
      claim_req    = ($urandom_range(0, 2) == 0);
      complete_req = ($urandom_range(0, 1) == 0);
      complete_id  = 4'($urandom_range(0, 15));
      core_wfi     = $urandom_range(0, 1) == 1;
      tick();
      checks++;
      if (claim_valid !== m_valid || claim_id !== m_id || external_interrupt !== m_ext || wfi_wake !== m_wake) begin
        failures++;
        $display("FAIL rand_c%0d got v=%0b id=%0d ext=%0b wake=%0b exp v=%0b id=%0d ext=%0b wake=%0b",
                 c, claim_valid, claim_id, external_interrupt, wfi_wake, m_valid, m_id, m_ext, m_wake);
      end
    end
    quiet(); irq_src = '0; core_wfi = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_complete();
    test_mask();
    test_simul();
    test_wfi();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
